alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter (with helper alu_arbiter_alu)
// Purpose  : Two-port round-robin arbiter/sequencer that owns one shared
//            combinational ALU. A requester raises req with op/a/b held
//            stable. The winner's operands are latched, the ALU result is
//            registered into 'result', and a one-cycle done pulse is
//            returned to that requester.
//            Sequence: IDLE -> EXEC -> DONE -> IDLE (3 cycles per op).
// Ports    : clk, rst_n (async, active-low)
//            req0/req1, op0/op1[2:0], a0/b0, a1/b1 [WIDTH-1:0]  requester side
//            lock0/lock1 (only with ALU_ARB_LOCK_EN)
//            gnt0/gnt1, done0/done1, result[WIDTH-1:0], busy
// Config   : `define ALU_ARB_LOCK_EN adds lock0/lock1. With lock, an owner
//            holding lock and req goes DONE -> EXEC directly (2 cycles/op).
// ALU ops  : 000 a&b, 001 a|b, 010 a^b, 011 ~a, 100 a+b, 101 a-b,
//            110 a, 111 b. The result is WIDTH bits; carry is discarded.
// Revision : 1.0 - initial release
// ============================================================================

module alu_arbiter_alu #(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_f
);
    always_comb begin
        o_f = '0;
        case (i_op)
            3'b000: o_f = i_a & i_b;
            3'b001: o_f = i_a | i_b;
            3'b010: o_f = i_a ^ i_b;
            3'b011: o_f = ~i_a;
            3'b100: o_f = i_a + i_b;   // wraps mod 2^WIDTH
            3'b101: o_f = i_a - i_b;
            3'b110: o_f = i_a;
            3'b111: o_f = i_b;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
`ifdef ALU_ARB_LOCK_EN
    input  logic             lock0,
    input  logic             lock1,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_owner;   // requester currently holding the ALU
    logic             r_rr;      // last requester served
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic             w_win;
    logic             w_hold;
    logic             w_sel;
    logic [WIDTH-1:0] w_f;

    // A lone request wins outright; on a tie the requester not served last wins.
    assign w_win = (req0 & req1) ? ~r_rr : req1;

`ifdef ALU_ARB_LOCK_EN
    assign w_hold = r_owner ? (lock1 & req1) : (lock0 & req0);
`else
    assign w_hold = 1'b0;
`endif

    // In DONE the only possible re-latch is the locked owner's new operation.
    assign w_sel = (r_state == ST_DONE) ? r_owner : w_win;

    alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_f  (w_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_rr    <= 1'b1;       // requester 0 wins the first tie
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            result  <= '0;
            busy    <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        r_state <= ST_EXEC;
                        r_owner <= w_win;
                        r_rr    <= w_win;
                        r_op    <= w_sel ? op1 : op0;
                        r_a     <= w_sel ? a1  : a0;
                        r_b     <= w_sel ? b1  : b0;
                        gnt0    <= ~w_win;
                        gnt1    <= w_win;
                        busy    <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // Completes even if the owner has withdrawn req.
                    result  <= w_f;
                    done0   <= ~r_owner;
                    done1   <= r_owner;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (w_hold) begin
                        // Grant stays up; rr is left as is so the other side is next.
                        r_state <= ST_EXEC;
                        r_op    <= w_sel ? op1 : op0;
                        r_a     <= w_sel ? a1  : a0;
                        r_b     <= w_sel ? b1  : b0;
                    end else begin
                        r_state <= ST_IDLE;
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. A transaction-level model
//            (owner, age of the running op, round-robin pointer, pending
//            result) predicts every output each cycle. Directed phases cover
//            reset, add, wrap, tie alternation, withdraw and lock; a random
//            phase follows. Honours ALU_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    localparam int WIDTH = 4;
`ifdef ALU_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req [2];
    logic [2:0]       op  [2];
    logic [WIDTH-1:0] a   [2];
    logic [WIDTH-1:0] b   [2];
    logic             lck [2];
    logic             gnt0, gnt1, done0, done1, busy;
    logic [WIDTH-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: owner (-1 = none), age 1 = executing, 2 = done cycle.
    int               m_owner;
    int               m_age;
    int               m_rr;
    logic [WIDTH-1:0] m_res;
    logic [WIDTH-1:0] m_pend;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req[0]),
        .req1   (req[1]),
        .op0    (op[0]),
        .op1    (op[1]),
        .a0     (a[0]),
        .b0     (b[0]),
        .a1     (a[1]),
        .b1     (b[1]),
`ifdef ALU_ARB_LOCK_EN
        .lock0  (lck[0]),
        .lock1  (lck[1]),
`endif
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] alu_ref(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        int m, xi, yi, r;
        m  = 1 << WIDTH;
        xi = int'(x);
        yi = int'(y);
        case (o)
            3'd0:    r = xi & yi;
            3'd1:    r = xi | yi;
            3'd2:    r = xi ^ yi;
            3'd3:    r = (m - 1) - xi;
            3'd4:    r = (xi + yi) % m;
            3'd5:    r = (xi - yi + m) % m;
            3'd6:    r = xi;
            default: r = yi;
        endcase
        return r[WIDTH-1:0];
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_rr    = 1;
        m_res   = '0;
        m_pend  = '0;
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        int w;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (req[0] || req[1]) begin
                w       = (req[0] && req[1]) ? 1 - m_rr : (req[1] ? 1 : 0);
                m_rr    = w;
                m_owner = w;
                m_age   = 1;
                m_pend  = alu_ref(op[w], a[w], b[w]);
            end
        end else if (m_age == 1) begin
            m_age = 2;
            m_res = m_pend;
        end else if (LOCK_EN && lck[m_owner] && req[m_owner]) begin
            m_age  = 1;
            m_pend = alu_ref(op[m_owner], a[m_owner], b[m_owner]);
        end else begin
            m_owner = -1;
        end
    endtask

    task automatic compare_all(input string ph);
        chk({ph, ":gnt0"},   gnt0,   m_owner == 0);
        chk({ph, ":gnt1"},   gnt1,   m_owner == 1);
        chk({ph, ":done0"},  done0,  m_owner == 0 && m_age == 2);
        chk({ph, ":done1"},  done1,  m_owner == 1 && m_age == 2);
        chk({ph, ":result"}, result, m_res);
        chk({ph, ":busy"},   busy,   m_owner >= 0);
        chk({ph, ":excl"},   gnt0 & gnt1, 1'b0);
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(ph);
    endtask

    task automatic new_ops(input int i);
        op[i]  = 3'($urandom_range(7));
        a[i]   = WIDTH'($urandom);
        b[i]   = WIDTH'($urandom);
        lck[i] = 1'($urandom_range(1));
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        model_reset();
        step("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Random requesters: drop/renew on done, occasional withdraw, random raise.
    task automatic react(input int drop_pct, input int raise_pct, input int wd_pct);
        for (int i = 0; i < 2; i++) begin
            bit dn;
            dn = (m_owner == i && m_age == 2);
            if (req[i]) begin
                if (dn) begin
                    if ($urandom_range(99) < drop_pct) req[i] = 1'b0;
                    else new_ops(i);
                end else if ($urandom_range(99) < wd_pct) begin
                    req[i] = 1'b0;
                end
            end else if ($urandom_range(99) < raise_pct) begin
                req[i] = 1'b1;
                new_ops(i);
            end else begin
                new_ops(i);   // idle requester wiggles its operands
            end
        end
    endtask

    initial begin
        int served[$];
        int d0[$];
        int cyc;

        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; op[i] = '0; a[i] = '0; b[i] = '0; lck[i] = 1'b0;
        end
        model_reset();
        repeat (2) step("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single add 3 + 5
        req[0] = 1'b1; op[0] = 3'b100; a[0] = 4'd3; b[0] = 4'd5;
        step("add_k");
        chk("add_gnt0", gnt0, 1'b1);
        step("add_k1");
        chk("add_done0", done0, 1'b1);
        chk("add_result", result, 4'd8);
        req[0] = 1'b0;
        step("add_k2");
        chk("add_idle", busy, 1'b0);

        // Wrap 9 + 9 = 2
        req[1] = 1'b1; op[1] = 3'b100; a[1] = 4'd9; b[1] = 4'd9;
        step("wrap_k");
        step("wrap_k1");
        chk("wrap_result", result, 4'd2);
        req[1] = 1'b0;
        step("wrap_k2");

        // Asynchronous reset in the middle of EXEC
        req[0] = 1'b1; op[0] = 3'b100; a[0] = 4'd1; b[0] = 4'd1;
        step("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst_async");
        chk("rst_async_gnt0", gnt0, 1'b0);
        step("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step("rerun_k");
        step("rerun_k1");
        chk("rerun_done0", done0, 1'b1);
        chk("rerun_result", result, 4'd2);
        req[0] = 1'b0;
        step("rerun_k2");

        // Tie from reset: both held, expect 0,1,0,1,0
        reset_dut();
        req[0] = 1'b1; new_ops(0); lck[0] = 1'b0;
        req[1] = 1'b1; new_ops(1); lck[1] = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step("tie");
            if (done0) served.push_back(0);
            if (done1) served.push_back(1);
            for (int i = 0; i < 2; i++)
                if (m_owner == i && m_age == 2) begin new_ops(i); lck[i] = 1'b0; end
        end
        chk("tie_count", served.size(), 5);
        foreach (served[j]) chk($sformatf("tie_order%0d", j), served[j], j % 2);
        req[0] = 1'b0; req[1] = 1'b0;
        repeat (3) step("tie_drain");

        // Withdraw: req1 drops right after its grant, req0 pending
        req[1] = 1'b1; op[1] = 3'b100; a[1] = 4'd7; b[1] = 4'd6; lck[1] = 1'b0;
        step("wd_gnt1");
        chk("wd_gnt1", gnt1, 1'b1);
        req[1] = 1'b0;
        req[0] = 1'b1; op[0] = 3'b101; a[0] = 4'd2; b[0] = 4'd5; lck[0] = 1'b0;
        step("wd_done1");
        chk("wd_done1", done1, 1'b1);
        chk("wd_result", result, 4'd13);
        step("wd_idle");
        step("wd_gnt0");
        chk("wd_next_gnt0", gnt0, 1'b1);
        step("wd_done0");
        chk("wd_sub_result", result, 4'd13);   // 2 - 5 wraps to 13
        req[0] = 1'b0;
        step("wd_end");

        // Lock: requester 0 locks for 3 ops while requester 1 waits
        reset_dut();
        req[0] = 1'b1; new_ops(0); lck[0] = 1'b1;
        req[1] = 1'b1; new_ops(1); lck[1] = 1'b0;
        cyc = 0;
        while (d0.size() < 3 && cyc < 40) begin
            step("lock");
            cyc++;
            if (done0) d0.push_back(cyc);
            if (m_owner == 0 && m_age == 2) begin
                if (d0.size() < 3) begin new_ops(0); lck[0] = 1'b1; end
                else begin req[0] = 1'b0; lck[0] = 1'b0; end
            end
            if (m_owner == 1 && m_age == 2) begin new_ops(1); lck[1] = 1'b0; end
        end
        chk("lock_ops", d0.size(), 3);
        if (d0.size() == 3) begin
            chk("lock_space1", d0[1] - d0[0], LOCK_EN ? 2 : 6);
            chk("lock_space2", d0[2] - d0[1], LOCK_EN ? 2 : 6);
        end
        req[0] = 1'b0; req[1] = 1'b0;
        repeat (8) step("lock_drain");

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step("rand");
            react(40, 30, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
